// File: rtl/game_pkg.sv
// Shared game definitions: button event codes as seen by the state-transition logic.
package game_pkg;

  typedef logic [2:0] btn_code_t;

  localparam btn_code_t BTN_CODE_NONE       = 3'd0;
  localparam btn_code_t BTN_CODE_RIGHT      = 3'd1;
  localparam btn_code_t BTN_CODE_LEFT       = 3'd2;
  localparam btn_code_t BTN_CODE_DOWN       = 3'd3;
  localparam btn_code_t BTN_CODE_UP         = 3'd4;
  localparam btn_code_t BTN_CODE_DECISION   = 3'd5;
  localparam btn_code_t BTN_CODE_RED_RESET  = 3'd6;
  localparam btn_code_t BTN_CODE_BLUE_RESET = 3'd7;

endpackage

// File: rtl/button_event_unit_if.sv
// Valid/ready event stream from the button front end to its consumer.
interface button_event_unit_if #(
  parameter int unsigned CODE_W = 3
) ();

  logic              evt_valid;
  logic [CODE_W-1:0] evt_code;
  logic              evt_ready;

  modport master (output evt_valid, output evt_code, input evt_ready);
  modport slave  (input evt_valid, input evt_code, output evt_ready);

endinterface

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus persistence-counter debounce for a single button.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw_i,
  output logic level_o,
  output logic rise_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q, sync_d;
  logic            level_q, level_d;
  logic            prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d  = {sync_q[0], btn_raw_i};
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  // One-cycle pulse the cycle after the stable level rises.
  assign rise_o  = level_q & ~prev_q;

endmodule

// File: rtl/button_event_unit.sv
// Debounced buttons -> prioritised press events in a show-ahead FIFO.
// Auto-repeat of held masked buttons is compiled in with BUTTON_AUTOREPEAT_EN.
module button_event_unit
  import game_pkg::*;
#(
  parameter int unsigned        NUM_BTN         = 7,
  parameter int unsigned        CODE_W          = $clog2(NUM_BTN + 1),
  parameter int unsigned        DEBOUNCE_CYCLES = 2_000_000,
  parameter int unsigned        FIFO_DEPTH      = 4,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = NUM_BTN'(7'b0001111),
  parameter int unsigned        REPEAT_DELAY    = 50_000_000,
  parameter int unsigned        REPEAT_PERIOD   = 12_500_000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_BTN-1:0]  btn_raw,
  output logic [NUM_BTN-1:0]  btn_level,
  button_event_unit_if.master evt,
  output logic                fifo_full,
  output logic [7:0]          drop_cnt
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  logic [NUM_BTN-1:0] rise, rep_req, set_req, grant, drop;
  logic [NUM_BTN-1:0] pending_q, pending_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;
  logic [CODE_W-1:0]  fifo_q [FIFO_DEPTH];
  logic [PtrW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic               empty, full, pop, push, can_push;
  logic [CODE_W-1:0]  push_code;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk      (clk),
      .reset_n  (reset_n),
      .btn_raw_i(btn_raw[i]),
      .level_o  (btn_level[i]),
      .rise_o   (rise[i])
    );
  end

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int unsigned TmrMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);
  localparam int unsigned OwnW   = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;

  logic [TmrW-1:0]    tmr_q, tmr_d;
  logic [OwnW-1:0]    own_q, own_d;
  logic               own_vld_q, own_vld_d;
  logic [NUM_BTN-1:0] masked_rise;

  always_comb begin
    masked_rise = rise & REPEAT_MASK;
    tmr_d       = tmr_q;
    own_d       = own_q;
    own_vld_d   = own_vld_q;
    rep_req     = '0;
    if (own_vld_q) begin
      if (!btn_level[own_q]) begin
        own_vld_d = 1'b0;
        tmr_d     = '0;
      end else if (tmr_q <= TmrW'(1)) begin
        rep_req[own_q] = 1'b1;
        tmr_d          = TmrW'(REPEAT_PERIOD);
      end else begin
        tmr_d = tmr_q - 1'b1;
      end
    end
    // A fresh masked press always takes ownership and restarts the initial delay.
    for (int i = 0; i < NUM_BTN; i++) begin
      if (masked_rise[i]) begin
        own_vld_d = 1'b1;
        own_d     = OwnW'(i);
        tmr_d     = TmrW'(REPEAT_DELAY);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmr_q     <= '0;
      own_q     <= '0;
      own_vld_q <= 1'b0;
    end else begin
      tmr_q     <= tmr_d;
      own_q     <= own_d;
      own_vld_q <= own_vld_d;
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_MASK, REPEAT_DELAY[0], REPEAT_PERIOD[0]};
  assign rep_req = '0;
`endif

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                    (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign pop      = !empty && evt.evt_ready;
  assign can_push = !full || pop;

  always_comb begin
    grant     = '0;
    push      = 1'b0;
    push_code = '0;
    if (can_push) begin
      // Scan downwards so the lowest pending index is the one left selected.
      for (int i = int'(NUM_BTN) - 1; i >= 0; i--) begin
        if (pending_q[i]) begin
          grant     = '0;
          grant[i]  = 1'b1;
          push      = 1'b1;
          push_code = CODE_W'(i + 1);
        end
      end
    end
  end

  always_comb begin
    set_req    = rise | rep_req;
    drop       = set_req & pending_q & ~grant;
    pending_d  = (pending_q & ~grant) | set_req;
    drop_cnt_d = drop_cnt_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (drop[i] && drop_cnt_d != 8'hFF) begin
        drop_cnt_d = drop_cnt_d + 8'd1;
      end
    end
    wr_ptr_d = wr_ptr_q + {{PtrW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{PtrW{1'b0}}, pop};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q  <= '0;
      drop_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      pending_q  <= pending_d;
      drop_cnt_q <= drop_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      if (push) begin
        fifo_q[wr_ptr_q[PtrW-1:0]] <= push_code;
      end
    end
  end

  assign evt.evt_valid = !empty;
  assign evt.evt_code  = empty ? CODE_W'(BTN_CODE_NONE) : fifo_q[rd_ptr_q[PtrW-1:0]];
  assign fifo_full     = full;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_button_event_unit.sv
// Directed bench for button_event_unit: table of single-shot presses plus
// hand-written backpressure, push/pop-when-full and reset sequences.
module tb_button_event_unit;

  localparam int unsigned NB = 7;
  localparam int unsigned CW = 3;
  localparam int          NV = 7;
  localparam int          WIN = 60;

  logic          clk;
  logic          reset_n;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic          fifo_full;
  logic [7:0]    drop_cnt;

  button_event_unit_if #(.CODE_W(CW)) evt_if ();

  button_event_unit #(
    .NUM_BTN        (NB),
    .CODE_W         (CW),
    .DEBOUNCE_CYCLES(4),
    .FIFO_DEPTH     (4),
    .REPEAT_MASK    (7'b0001111),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .evt      (evt_if),
    .fifo_full(fifo_full),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NB-1:0] raw;
    int            hold;
    int            exp_n;
    int            exp_edge0;
    int            exp_code0;
    int            exp_edge1;
    int            exp_code1;
  } vec_t;

  vec_t vecs [NV];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input int b, input int hold, input int gap);
    btn_raw[b] = 1'b1;
    repeat (hold) @(negedge clk);
    btn_raw[b] = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int edges [4];
    int codes [4];

    // raw, hold, n, edge0, code0, edge1, code1
    vecs[0] = '{7'b0001000,  3, 0, 0, 0, 0, 0};  // glitch on btn 3
    vecs[1] = '{7'b0001000, 10, 1, 7, 4, 0, 0};
    vecs[2] = '{7'b0000001,  4, 1, 7, 1, 0, 0};  // exactly DEBOUNCE_CYCLES high
    vecs[3] = '{7'b1000000,  8, 1, 7, 7, 0, 0};
    vecs[4] = '{7'b0100010, 10, 2, 7, 2, 8, 6};  // priority: btn 1 before btn 5
    vecs[5] = '{7'b0100000, 40, 1, 7, 6, 0, 0};  // unmasked, never repeats
`ifdef BUTTON_AUTOREPEAT_EN
    vecs[6] = '{7'b0000100, 36, 3, 7, 3, 27, 3}; // press, +20, +8, stops on release
`else
    vecs[6] = '{7'b0000100, 36, 1, 7, 3, 0, 0};
`endif

    reset_n = 1'b0;
    btn_raw = '0;
    evt_if.evt_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", evt_if.evt_valid, 0);
    check("rst_code", evt_if.evt_code, 0);
    check("rst_full", fifo_full, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_level", btn_level, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < NV; v++) begin
      n = 0;
      for (int c = 0; c < WIN; c++) begin
        btn_raw = (c < vecs[v].hold) ? vecs[v].raw : '0;
        @(negedge clk);
        if (evt_if.evt_valid) begin
          if (n < 4) begin
            edges[n] = c;
            codes[n] = int'(evt_if.evt_code);
          end
          n++;
        end
      end
      check($sformatf("v%0d_count", v), n, vecs[v].exp_n);
      if (vecs[v].exp_n >= 1 && n >= 1) begin
        check($sformatf("v%0d_edge0", v), edges[0], vecs[v].exp_edge0);
        check($sformatf("v%0d_code0", v), codes[0], vecs[v].exp_code0);
      end
      if (vecs[v].exp_n >= 2 && n >= 2) begin
        check($sformatf("v%0d_edge1", v), edges[1], vecs[v].exp_edge1);
        check($sformatf("v%0d_code1", v), codes[1], vecs[v].exp_code1);
      end
      check($sformatf("v%0d_level_idle", v), btn_level, 0);
    end
    check("drop_after_table", drop_cnt, 0);

    // Backpressure: four presses fill the queue, the fifth waits as pending.
    evt_if.evt_ready = 1'b0;
    for (int b = 0; b < 5; b++) press(b, 6, 8);
    check("bp_full", fifo_full, 1);
    check("bp_head", evt_if.evt_code, 1);
    check("bp_drop0", drop_cnt, 0);
    press(4, 6, 8);
    check("bp_drop1", drop_cnt, 1);

    // One accept while full: pending btn 4 is pushed in the same cycle.
    evt_if.evt_ready = 1'b1;
    @(negedge clk);
    evt_if.evt_ready = 1'b0;
    check("pp_full", fifo_full, 1);
    check("pp_head", evt_if.evt_code, 2);
    check("pp_drop", drop_cnt, 1);
    @(negedge clk);
    evt_if.evt_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain_code%0d", k), evt_if.evt_code, k + 2);
      @(negedge clk);
    end
    check("drain_empty", evt_if.evt_valid, 0);
    check("drain_full", fifo_full, 0);

    // Reset with three queued events and a button held high.
    evt_if.evt_ready = 1'b0;
    for (int b = 0; b < 3; b++) press(b, 6, 8);
    btn_raw[6] = 1'b1;
    repeat (7) @(negedge clk);
    check("pre_rst_level", btn_level[6], 1);
    check("pre_rst_drop", drop_cnt, 1);
    check("pre_rst_valid", evt_if.evt_valid, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", evt_if.evt_valid, 0);
    check("mid_rst_drop", drop_cnt, 0);
    check("mid_rst_level", btn_level, 0);
    check("mid_rst_full", fifo_full, 0);
    btn_raw = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    evt_if.evt_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (evt_if.evt_valid) n++;
    end
    check("post_rst_events", n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_event_unit.md
# button_event_unit

Parametrised front end between raw push-buttons and the game state machine. It synchronises and debounces `NUM_BTN` buttons and detects press edges. Each press is encoded as a 1-based button code and queued in a small event FIFO behind a valid/ready handshake, so the state-transition logic consumes exactly one event per press instead of sampling levels on a slow clock. It also provides optional auto-repeat for held direction buttons.

## Interface
Parameters:
- `NUM_BTN`, 7, number of buttons; index 0 has highest arbitration priority.
- `CODE_W`, `$clog2(NUM_BTN+1)`, event code width; code 0 is never emitted.
- `DEBOUNCE_CYCLES`, 2_000_000, consecutive cycles a level change must persist.
- `FIFO_DEPTH`, 4, event queue depth; power of two, ≥2.
- `REPEAT_MASK`, 7'b0001111, buttons eligible for auto-repeat.
- `REPEAT_DELAY`, 50_000_000, cycles from press to first repeat.
- `REPEAT_PERIOD`, 12_500_000, cycles between subsequent repeats.

Ports:
- `clk` in 1: single system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `btn_raw` in NUM_BTN: raw buttons, active-high, asynchronous.
- `btn_level` out NUM_BTN: debounced levels.
- `evt_valid` out 1: FIFO head valid.
- `evt_code` out CODE_W: button index + 1. Reads 0 when `evt_valid` is low.
- `evt_ready` in 1: consumer accepts the head.
- `fifo_full` out 1: FIFO holds FIFO_DEPTH entries.
- `drop_cnt` out 8: saturating count of lost presses.

## Operation
- **Reset values.** All outputs are 0. Sync flops, stable levels, debounce counters, pending flags, FIFO pointers and the repeat timer are all cleared. Reset mid-operation discards queued events immediately.
- **Sync.** Each `btn_raw` bit passes through a 2-flop synchroniser.
- **Debounce (per button).** A counter increments while the sync output differs from the stable level. It clears when they match. When the count reaches DEBOUNCE_CYCLES−1 with a mismatch, the stable level toggles and the counter clears.
- **Press.** A stable 0→1 transition sets `pending[i]`. A press on a button whose pending flag is already set increments `drop_cnt`; `drop_cnt` saturates at 255.
- **Arbiter.** Each cycle the FIFO is not full, the lowest-index pending button is written as code i+1 and its flag is cleared. At most one write per cycle. While the FIFO is full, pending flags hold and are not lost.
- **FIFO.**
  - Show-ahead: `evt_valid` = not empty, and `evt_code` = head.
  - A pop occurs when `evt_valid && evt_ready`.
  - Push and pop in the same cycle are both performed. When full, a same-cycle pop frees a slot and the push is accepted.
  - `evt_ready` while empty has no effect.
- **Release.** Releases generate no events.
- **Auto-repeat** (only when compiled in):
  - The repeat owner is the most recently pressed button within REPEAT_MASK.
  - Any new press of a masked button reloads the timer with REPEAT_DELAY and takes ownership.
  - When the timer expires while the owner is stable-high, the owner's pending flag is set, following the same drop rule as a press, and the timer reloads REPEAT_PERIOD.
  - Owner release clears ownership and stops the timer.
  - Presses of unmasked buttons do not affect the owner.

## Timing
- **Press latency.** With `btn_raw[i]` sampled high first at edge 0, the FIFO idle and no contention:
  - stable level rises at edge DEBOUNCE_CYCLES+1;
  - pending rises at +1;
  - FIFO write at +1;
  - `evt_valid`/`evt_code` are visible after edge DEBOUNCE_CYCLES+3.
- **Arbitration.** With contention, each extra pending button adds 1 cycle, in index order.
- **Throughput.** One event per cycle in and one event per cycle out.
- **Glitches.** A glitch shorter than DEBOUNCE_CYCLES cycles produces no level change and no event.

## Configuration
- **`BUTTON_AUTOREPEAT_EN` defined:** the repeat owner and timer exist, and behaviour is as above.
- **`BUTTON_AUTOREPEAT_EN` undefined:** no repeat logic is synthesised. A held button yields exactly one event. The REPEAT_* parameters are accepted but ignored.

## Structure
- **Shared package `game_pkg`:**
  - `BTN_CODE_NONE` = 0;
  - named code constants for the seven game buttons (RIGHT = 1, LEFT, DOWN, UP, DECISION, RED_RESET, BLUE_RESET = 7);
  - a `btn_code_t` typedef.
- **Sub-module:** `button_debounce` (sync plus debounce for one button, instantiated NUM_BTN times via generate). The FIFO and arbiter stay inline.

## Test plan
Run with DEBOUNCE_CYCLES = 4, FIFO_DEPTH = 4, REPEAT_DELAY = 20, REPEAT_PERIOD = 8, `evt_ready` = 1 unless stated.

- **Reset.** Assert `reset_n` = 0 mid-run with 3 events queued → `evt_valid` = 0, `drop_cnt` = 0 and `btn_level` = 0 immediately; no stale events after release.
- **Glitch rejection.** `btn_raw[3]` high for 3 cycles → no event. Held for 10 cycles → exactly one event, code 4, at edge 7 after first sample.
- **Priority.** Buttons 5 and 1 rise on the same cycle → events code 2 then code 6 on consecutive cycles.
- **Backpressure.** `evt_ready` = 0; press buttons 0, 1, 2, 3, 4 sequentially → `fifo_full` = 1 and the fifth press held pending. Re-press button 4 before draining → `drop_cnt` = 1. Set `evt_ready` = 1 → codes 1, 2, 3, 4, 5 in order.
- **Auto-repeat.** Hold button 2 (masked) with `BUTTON_AUTOREPEAT_EN` → code 3 at press, then +20 cycles, then every 8 cycles; stops on release. Hold button 5 → a single code 6. Without the macro, button 2 → a single event.
- **Simultaneous push/pop when full.** A new press arrives as the head is accepted → accepted, no drop, count stays 4.
